// File: rtl/alu_pkg.sv
// Shared definitions for the serial negate / absolute-value datapath:
// operation encodings, FSM state type and default geometry.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int DEFAULT_DIGIT = 1;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Decide at capture time whether the operand gets two's-complement negated.
  // Absolute mode negates only negative operands; pass and reserved never do.
  function automatic logic negate_for(input logic [1:0] mode, input logic sign);
    case (mode)
      MODE_NEG: return 1'b1;
      MODE_ABS: return sign;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder slice. The serial negator reuses one instance
// for every step, chaining the carry through a register between cycles.
module digit_adder #(
  parameter int DIGIT = alu_pkg::DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  // Ripple the carry from the least-significant bit upward.
  always_comb begin : ripple
    logic c;
    // NOTE: every variable written here gets a value before any conditional or
    // loop touches it; otherwise synthesis infers a latch to hold the old value.
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_negator.sv
// Digit-serial pass / negate / absolute-value unit. An operand is captured in
// IDLE, processed DIGIT bits per cycle LSB-first through one shared adder
// slice (~x + 1 for negation, x + 0 for pass), then held in DONE until the
// consumer takes it.
module serial_negator
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       ovf,
  output logic             err
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS) + 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_negator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  xs;          // operand, shifted right one digit per step
  logic              neg;         // negate decision frozen at capture
  logic              carry;       // carry between successive digits
  logic [CNT_W-1:0]  step;
  logic [DIGIT-1:0]  xd;
  logic [DIGIT-1:0]  addend;
  logic [DIGIT-1:0]  sum;
  logic              cout;
  logic              last_step;
  logic              capture_neg;

  assign xd          = xs[DIGIT-1:0];
  assign addend      = neg ? ~xd : xd;
  assign last_step   = (step == CNT_W'(STEPS - 1));
  assign capture_neg = negate_for(mode, x[WIDTH-1]);

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a    (addend),
    .b    ({DIGIT{1'b0}}),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: accept in IDLE, count digits in SHIFT, wait in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready and valid are mutually exclusive.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture operand, then shift one digit of result in per step.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand register is reset along with the visible outputs so an
    // aborted operation leaves no stale operand behind; it is only a few flops.
    if (!rst_n) begin
      xs    <= '0;
      neg   <= 1'b0;
      carry <= 1'b0;
      step  <= '0;
      y     <= '0;
      ovf   <= 2'b00;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xs    <= x;
            neg   <= capture_neg;
            carry <= capture_neg;
            step  <= '0;
            y     <= '0;
            ovf   <= 2'b00;
            err   <= (mode == MODE_RSVD);
          end
        end
        SHIFT: begin
          xs    <= xs >> DIGIT;
          y     <= (y >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
          carry <= cout;
          step  <= step + CNT_W'(1);
          if (last_step) begin
            // Carry out survives only for ~0 + 1; signed overflow only when a
            // negative operand stays negative, i.e. the most negative value.
            ovf <= {cout, neg & xd[DIGIT-1] & sum[DIGIT-1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
